systolic_job_arbiter: RTL and testbench
=======================================

Name: systolic_job_arbiter

Overview:
- Sequencer and arbiter in front of the 4x4 8-bit systolic array top.
- Two requesters submit matrix pairs (A, B) over valid/ready; the block grants one round-robin, pulses the array's valid-input strobe with the latched operands, and waits for the array's result strobe.
- Returns the 4x4 16-bit product on a shared response channel tagged with requester ID. Only one job is in flight at a time.

Parameters:
- TIMEOUT_CYCLES, 16, cycles spent in WAIT without a result strobe before the job is retired with error; legal range 12..255.
- RR_INIT, 0, requester that has priority after reset (0 or 1).

Ports:
- i_clk  in  1  clock
- i_arst  in  1  asynchronous active-high reset
- i_reqValid  in  [1:0]  per-requester job valid
- o_reqReady  out  [1:0]  per-requester accept; at most one bit high
- i_reqA  in  [1:0][3:0][3:0][7:0]  per-requester matrix A
- i_reqB  in  [1:0][3:0][3:0][7:0]  per-requester matrix B
- o_rspValid  out  1  response valid
- i_rspReady  in  1  response accept
- o_rspId  out  1  requester that owns the response
- o_rspC  out  [3:0][3:0][15:0]  product matrix
- o_rspErr  out  1  job timed out; o_rspC is zero
- o_arrValidInput  out  1  strobe to the array's valid-input port
- o_arrA  out  [3:0][3:0][7:0]  operand A to the array
- o_arrB  out  [3:0][3:0][7:0]  operand B to the array
- i_arrC  in  [3:0][3:0][15:0]  array result
- i_arrValidResult  in  1  array result strobe
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - State IDLE; rr pointer = RR_INIT; wait counter 0.
  - o_arrA, o_arrB, result, ID and error registers cleared.
  - All outputs 0, except o_reqReady, which follows IDLE arbitration from the first cycle after reset release.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE arbitration:
  - Grant goes to the rr-pointer requester if its valid is high, else to the other requester if its valid is high.
  - o_reqReady is high only for the granted requester.
  - The handshake is valid&ready. On handshake: latch A/B into o_arrA/o_arrB, latch the ID, go to ISSUE.
  - If neither requester is valid, no ready is asserted and the state stays IDLE.
- ISSUE (exactly 1 cycle):
  - o_arrValidInput = 1; o_arrA/o_arrB hold the latched operands.
  - Clear the wait counter; next state WAIT.
- WAIT:
  - The wait counter increments each cycle.
  - If i_arrValidResult = 1: capture i_arrC, clear the error flag, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1: set the error flag, clear the result, go to RESP.
  - If the result strobe and the timeout occur in the same cycle, the result wins.
- RESP:
  - o_rspValid = 1; o_rspId, o_rspC and o_rspErr stay stable until i_rspReady.
  - On handshake: rr pointer = ~granted ID, next state IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake.
- i_arrValidResult is ignored in IDLE, ISSUE and RESP. The array's free-running counter re-strobes periodically, so these spurious strobes must not disturb state or the captured result.
- o_arrA/o_arrB hold their values after ISSUE until the next accept. The array reloads only on o_arrValidInput.
- Nominal latency: accept handshake at cycle T, o_arrValidInput at T+1, i_arrValidResult at T+12, o_rspValid at T+13.
- Reset asserted mid-job: the job is dropped with no response, and the array is not re-strobed.

Optional Feature:
- SYSARR_PERF_CNT_EN, when defined, adds three outputs:
  - o_jobCount [15:0]: increments on each response handshake with err = 0.
  - o_errCount [15:0]: increments on each response handshake with err = 1.
  - o_busyCycles [31:0]: increments every cycle o_busy = 1.
- All three counters reset to 0 and saturate at all-ones.
- When SYSARR_PERF_CNT_EN is not defined, these ports and registers do not exist.

Test Plan:
- Single job: requester 0 sends A = identity, B[i][j] = 4i+j. Required: o_reqReady[0] for 1 cycle; one o_arrValidInput pulse; o_rspValid 13 cycles after accept with C[i][j] = 4i+j, id = 0, err = 0.
- Contention: both valid continuously with RR_INIT = 0. Required: grants in order 0, 1, 0, 1; o_reqReady is never 2'b11; each response ID matches its grant.
- Backpressure: hold i_rspReady = 0 for 20 cycles, with an extra i_arrValidResult pulse injected during RESP. Required: o_rspC/o_rspId unchanged; no new o_reqReady until the handshake.
- Timeout: the array model never strobes, TIMEOUT_CYCLES = 16. Required: o_rspValid with err = 1 and C = 0, 17 cycles after accept; state returns to IDLE.
- Spurious strobe: pulse i_arrValidResult while in IDLE and ISSUE. Required: no state change and no response.
- Reset mid-WAIT: assert i_arst 5 cycles after issue. Required: o_rspValid = 0, o_busy = 0, o_arrValidInput = 0 immediately; the next job runs normally. With SYSARR_PERF_CNT_EN, all counters read 0.

Source files
------------

// File: rtl/systolic_job_arbiter.sv
// Round-robin job sequencer in front of the 4x4 systolic array; optional SYSARR_PERF_CNT_EN adds perf counters.
// Accept->issue 1 cycle, result->response 1 cycle, 16-cycle WAIT timeout; response held until i_rspReady, no accept meanwhile.
`timescale 1ns/1ps
module systolic_job_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic        RR_INIT        = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_arst,
    input  logic [1:0]              i_reqValid,
    output logic [1:0]              o_reqReady,
    input  logic [1:0][3:0][3:0][7:0] i_reqA,
    input  logic [1:0][3:0][3:0][7:0] i_reqB,
    output logic                    o_rspValid,
    input  logic                    i_rspReady,
    output logic                    o_rspId,
    output logic [3:0][3:0][15:0]   o_rspC,
    output logic                    o_rspErr,
    output logic                    o_arrValidInput,
    output logic [3:0][3:0][7:0]    o_arrA,
    output logic [3:0][3:0][7:0]    o_arrB,
    input  logic [3:0][3:0][15:0]   i_arrC,
    input  logic                    i_arrValidResult,
`ifdef SYSARR_PERF_CNT_EN
    output logic [15:0]             o_jobCount,
    output logic [15:0]             o_errCount,
    output logic [31:0]             o_busyCycles,
`endif
    output logic                    o_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e                 state_q, state_d;
    logic                   rr_q, rr_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [3:0][3:0][7:0]   a_q, a_d, b_q, b_d;
    logic [3:0][3:0][15:0]  c_q, c_d;
    logic                   id_q, id_d;
    logic                   err_q, err_d;
    logic [1:0]             grant;
    logic                   gnt_id;

    // Ready is held low while reset is asserted so it only follows arbitration after release.
    always_comb begin
        grant  = 2'b00;
        gnt_id = rr_q;
        if (state_q == IDLE && !i_arst) begin
            if (i_reqValid[rr_q]) begin
                grant[rr_q] = 1'b1;
                gnt_id      = rr_q;
            end else if (i_reqValid[~rr_q]) begin
                grant[~rr_q] = 1'b1;
                gnt_id       = ~rr_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        id_d    = id_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    a_d     = i_reqA[gnt_id];
                    b_d     = i_reqB[gnt_id];
                    id_d    = gnt_id;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = 8'd0;
                state_d = WAIT;
            end
            WAIT: begin
                // Compare the incremented count so the timeout lands TIMEOUT_CYCLES+1 cycles after accept.
                cnt_d = cnt_q + 8'd1;
                if (i_arrValidResult) begin
                    c_d     = i_arrC;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_d == 8'(TIMEOUT_CYCLES - 1)) begin
                    c_d     = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (i_rspReady) begin
                    rr_d    = ~id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= IDLE;
            rr_q    <= RR_INIT;
            cnt_q   <= 8'd0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    assign o_reqReady      = grant;
    assign o_arrValidInput = (state_q == ISSUE);
    assign o_arrA          = a_q;
    assign o_arrB          = b_q;
    assign o_rspValid      = (state_q == RESP);
    assign o_rspId         = id_q;
    assign o_rspC          = c_q;
    assign o_rspErr        = err_q;
    assign o_busy          = (state_q != IDLE);

`ifdef SYSARR_PERF_CNT_EN
    logic [15:0] job_cnt_q, err_cnt_q;
    logic [31:0] busy_cnt_q;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            job_cnt_q  <= 16'd0;
            err_cnt_q  <= 16'd0;
            busy_cnt_q <= 32'd0;
        end else begin
            if (state_q == RESP && i_rspReady) begin
                if (err_q && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
                if (!err_q && job_cnt_q != 16'hFFFF) job_cnt_q <= job_cnt_q + 16'd1;
            end
            if (o_busy && busy_cnt_q != 32'hFFFF_FFFF) busy_cnt_q <= busy_cnt_q + 32'd1;
        end
    end

    assign o_jobCount   = job_cnt_q;
    assign o_errCount   = err_cnt_q;
    assign o_busyCycles = busy_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_job_arbiter.sv
// Bench for systolic_job_arbiter: array model, scoreboard of expected responses, round-robin reference.
`timescale 1ns/1ps
module tb_systolic_job_arbiter;

    typedef struct {
        logic         id;
        logic         err;
        logic [255:0] c;
        int           acc;
        int           lat;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      arst;
    logic [1:0]                req_vld;
    logic [1:0]                req_rdy;
    logic [1:0][3:0][3:0][7:0] req_a, req_b;
    logic                      rsp_vld, rsp_rdy, rsp_id, rsp_err;
    logic [3:0][3:0][15:0]     rsp_c;
    logic                      arr_vin;
    logic [3:0][3:0][7:0]      arr_a, arr_b;
    logic [3:0][3:0][15:0]     arr_c, arr_c_in;
    logic                      arr_vres, busy;
`ifdef SYSARR_PERF_CNT_EN
    logic [15:0] job_cnt, err_cnt;
    logic [31:0] busy_cnt;
`endif

    systolic_job_arbiter #(.TIMEOUT_CYCLES(16), .RR_INIT(1'b0)) dut (
        .i_clk(clk), .i_arst(arst),
        .i_reqValid(req_vld), .o_reqReady(req_rdy),
        .i_reqA(req_a), .i_reqB(req_b),
        .o_rspValid(rsp_vld), .i_rspReady(rsp_rdy), .o_rspId(rsp_id),
        .o_rspC(rsp_c), .o_rspErr(rsp_err),
        .o_arrValidInput(arr_vin), .o_arrA(arr_a), .o_arrB(arr_b),
        .i_arrC(arr_c_in), .i_arrValidResult(arr_vres),
`ifdef SYSARR_PERF_CNT_EN
        .o_jobCount(job_cnt), .o_errCount(err_cnt), .o_busyCycles(busy_cnt),
`endif
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_chk = 0, n_pass = 0;
    int   n_rsp = 0, n_issue = 0, n_rdy0 = 0;
    exp_t sb[$];
    logic grants[$];
    logic rr_m = 1'b0;
    logic rsp_prev = 1'b0;
    logic hs_flag = 1'b0, hs_r = 1'b0;
    logic [1:0] refresh = 2'b00;
    logic arr_en, arr_inj, inj_issue;
    int   cd;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0][3:0][15:0] matmul(input logic [3:0][3:0][7:0] a,
                                                     input logic [3:0][3:0][7:0] b);
        logic [3:0][3:0][15:0] c;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                c[i][j] = 16'd0;
                for (int k = 0; k < 4; k++) c[i][j] += 16'(a[i][k]) * 16'(b[k][j]);
            end
        return c;
    endfunction

    // Array stand-in: result strobe 11 cycles after the valid-input pulse.
    always @(posedge clk or posedge arst) begin
        if (arst) begin
            cd    <= 0;
            arr_c <= '0;
        end else if (arr_vin && arr_en) begin
            cd    <= 11;
            arr_c <= matmul(arr_a, arr_b);
        end else if (cd != 0) begin
            cd <= cd - 1;
        end
    end
    assign arr_vres = (cd == 1) || arr_inj;
    assign arr_c_in = arr_inj ? {16{16'hDEAD}} : arr_c;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic new_job(input int r);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                req_a[r][i][j] = 8'($urandom_range(0, 255));
                req_b[r][i][j] = 8'($urandom_range(0, 255));
            end
    endtask

    task automatic monitor();
        exp_t e;
        logic r, eg;
        check("rdy_not_both", req_rdy == 2'b11, 1'b0);
        if (req_rdy[0]) n_rdy0++;
        if (arr_vin) n_issue++;
        if (|(req_vld & req_rdy)) begin
            r  = req_rdy[1];
            eg = req_vld[rr_m] ? rr_m : ~rr_m;
            check("grant_id", r, eg);
            e.id  = r;
            e.err = !arr_en;
            e.c   = arr_en ? matmul(req_a[r], req_b[r]) : '0;
            e.acc = cyc;
            e.lat = arr_en ? 13 : 17;
            sb.push_back(e);
            grants.push_back(r);
            hs_flag = 1'b1;
            hs_r    = r;
        end
        if (rsp_vld && !rsp_prev) begin
            if (sb.size() == 0) check("rsp_unexpected", 1, 0);
            else check("rsp_latency", cyc - sb[0].acc, sb[0].lat);
        end
        if (rsp_vld && rsp_rdy && sb.size() != 0) begin
            e = sb.pop_front();
            check("rsp_id", rsp_id, e.id);
            check("rsp_err", rsp_err, e.err);
            check("rsp_c", rsp_c, e.c);
            rr_m = ~e.id;
            n_rsp++;
        end
        rsp_prev = rsp_vld;
    endtask

    task automatic step();
        @(negedge clk);
        if (!arst) monitor();
        @(posedge clk);
        #1;
        arr_inj = 1'b0;
        if (hs_flag) begin
            if (refresh[hs_r]) new_job(int'(hs_r));
            else req_vld[hs_r] = 1'b0;
            hs_flag = 1'b0;
        end
        if (inj_issue && arr_vin) begin
            arr_inj   = 1'b1;
            inj_issue = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int k = 0;
        while (n_rsp < target && k < budget) begin
            step();
            k++;
        end
        check("rsp_arrived", n_rsp >= target, 1'b1);
    endtask

    initial begin
        logic [255:0] c0;
        logic [255:0] c_ident;
        logic         id0;
        int           i0, k;

        arst = 1'b1; req_vld = 2'b01; rsp_rdy = 1'b1;
        arr_en = 1'b1; arr_inj = 1'b0; inj_issue = 1'b0;
        new_job(0); new_job(1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", req_rdy, 2'b00);
        check("rst_rspvld", rsp_vld, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_arrvin", arr_vin, 1'b0);
        check("rst_arra", arr_a, '0);
        check("rst_rspc", rsp_c, '0);
        req_vld = 2'b00;
        @(posedge clk);
        #1;
        arst = 1'b0;
        step();
        check("idle_rdy", req_rdy, 2'b00);
        check("idle_busy", busy, 1'b0);

        // Contention: both requesters always valid.
        grants.delete();
        refresh = 2'b11;
        req_vld = 2'b11;
        wait_rsp(4, 120);
        req_vld = 2'b00;
        refresh = 2'b00;
        check("grant_cnt", grants.size(), 4);
        for (int g = 0; g < 4 && g < grants.size(); g++) check("grant_order", grants[g], g % 2);

        // Single job: identity times 4i+j.
        repeat (2) step();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                req_a[0][i][j] = (i == j) ? 8'd1 : 8'd0;
                req_b[0][i][j] = 8'(4 * i + j);
                c_ident[(i*4+j)*16 +: 16] = 16'(4 * i + j);
            end
        check("ident_model", matmul(req_a[0], req_b[0]), c_ident);
        n_rdy0 = 0; i0 = n_issue;
        req_vld[0] = 1'b1;
        wait_rsp(n_rsp + 1, 40);
        check("single_rdy_cycles", n_rdy0, 1);
        check("single_issue_pulses", n_issue - i0, 1);

        // Spurious strobes in IDLE and ISSUE.
        step();
        arr_inj = 1'b1;
        step();
        check("spur_idle_busy", busy, 1'b0);
        check("spur_idle_rsp", rsp_vld, 1'b0);
        inj_issue = 1'b1;
        new_job(1);
        req_vld[1] = 1'b1;
        wait_rsp(n_rsp + 1, 40);
        check("spur_issue_used", inj_issue, 1'b0);

        // Backpressure with a stray strobe during RESP.
        rsp_rdy = 1'b0;
        new_job(1);
        req_vld[1] = 1'b1;
        k = 0;
        while (!rsp_vld && k < 40) begin step(); k++; end
        check("bp_rsp_seen", rsp_vld, 1'b1);
        c0 = rsp_c; id0 = rsp_id;
        new_job(0);
        req_vld[0] = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (t == 5) arr_inj = 1'b1;
            step();
            check("bp_rspc_stable", rsp_c, c0);
            check("bp_id_stable", rsp_id, id0);
            check("bp_no_ready", req_rdy, 2'b00);
        end
        rsp_rdy = 1'b1;
        wait_rsp(n_rsp + 2, 60);

        // Timeout: array never strobes.
        step();
        arr_en = 1'b0;
        new_job(0);
        req_vld[0] = 1'b1;
        wait_rsp(n_rsp + 1, 40);
        step();
        check("to_idle_busy", busy, 1'b0);
        arr_en = 1'b1;

`ifdef SYSARR_PERF_CNT_EN
        check("perf_err_before_rst", err_cnt, 16'd1);
`endif

        // Reset five cycles after issue.
        i0 = n_issue;
        new_job(0);
        req_vld[0] = 1'b1;
        k = 0;
        while (n_issue == i0 && k < 30) begin step(); k++; end
        check("rst_issue_seen", n_issue - i0, 1);
        repeat (4) step();
        check("rst_in_wait", busy, 1'b1);
        arst = 1'b1;
        #1;
        check("rstw_rspvld", rsp_vld, 1'b0);
        check("rstw_busy", busy, 1'b0);
        check("rstw_arrvin", arr_vin, 1'b0);
`ifdef SYSARR_PERF_CNT_EN
        check("perf_job0", job_cnt, 16'd0);
        check("perf_err0", err_cnt, 16'd0);
        check("perf_busy0", busy_cnt, 32'd0);
`endif
        sb.delete();
        rr_m = 1'b0; rsp_prev = 1'b0; hs_flag = 1'b0;
        req_vld = 2'b00;
        repeat (2) step();
        arst = 1'b0;
        step();
        check("rstw_no_issue", arr_vin, 1'b0);
        new_job(1);
        req_vld[1] = 1'b1;
        wait_rsp(n_rsp + 1, 40);
        repeat (3) step();
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
